// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC IR frame/repeat transmitter; tx_valid/tx_ready accept addr/cmd/repeat, drives ir_env envelope, ir_out carrier-modulated, tx_done on return to idle
module nec_ir_tx #(
  parameter int UNIT_CYCLES = 14063,
  parameter int CARRIER_HALF = 329
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  input  logic       tx_repeat,
  output logic       ir_out,
  output logic       ir_env,
  output logic       tx_done
);
  localparam int UW = $clog2(UNIT_CYCLES);
  localparam int PW = $clog2(2 * CARRIER_HALF);
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;
  state_t state, state_n;
  logic [UW-1:0] cyc, cyc_n;
  logic [3:0] units, units_n, dur;
  logic [4:0] bit_idx, bit_idx_n;
  logic [31:0] shreg, shreg_n;
  logic [PW-1:0] phase, phase_n;
  logic rpt, rpt_n, done_n, unit_end, state_end, mark_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cyc <= '0;
      units <= '0;
      bit_idx <= '0;
      shreg <= '0;
      phase <= '0;
      rpt <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cyc <= cyc_n;
      units <= units_n;
      bit_idx <= bit_idx_n;
      shreg <= shreg_n;
      phase <= phase_n;
      rpt <= rpt_n;
      tx_done <= done_n;
    end
  end
  always_comb begin
    dur = state == LEAD_MARK ? 4'd15 :
          state == LEAD_SPACE ? (rpt ? 4'd3 : 4'd7) :
          (state == BIT_SPACE && shreg[0]) ? 4'd2 : 4'd0;
    unit_end = state != IDLE && cyc == UW'(UNIT_CYCLES - 1);
    state_end = unit_end && units == dur;
    state_n = state;
    rpt_n = rpt;
    shreg_n = shreg;
    bit_idx_n = bit_idx;
    done_n = 1'b0;
    case (state)
      IDLE: if (tx_valid) begin
        state_n = LEAD_MARK;
        shreg_n = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
        rpt_n = tx_repeat;
        bit_idx_n = '0;
      end
      LEAD_MARK: if (state_end) state_n = LEAD_SPACE;
      LEAD_SPACE: if (state_end) state_n = rpt ? STOP_MARK : BIT_MARK;
      BIT_MARK: if (state_end) state_n = BIT_SPACE;
      BIT_SPACE: if (state_end) begin
        shreg_n = shreg >> 1;
        bit_idx_n = bit_idx + 5'd1;
        state_n = bit_idx == 5'd31 ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: if (state_end) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    cyc_n = (state == IDLE || state_n != state || unit_end) ? '0 : cyc + UW'(1);
    units_n = state_n != state ? '0 : unit_end ? units + 4'd1 : units;
    mark_n = state_n inside {LEAD_MARK, BIT_MARK, STOP_MARK};
    phase_n = (!mark_n || state_n != state || phase == PW'(2 * CARRIER_HALF - 1)) ? '0 : phase + PW'(1);
  end
  assign tx_ready = state == IDLE;
  assign ir_env = state inside {LEAD_MARK, BIT_MARK, STOP_MARK};
  assign ir_out = ir_env && phase < PW'(CARRIER_HALF);
endmodule

// File: tb/tb_nec_ir_tx.sv
// tb_nec_ir_tx: directed self-checking bench for nec_ir_tx with U=20, carrier period 4
module tb_nec_ir_tx;
  localparam int MAXC = 5000;
  logic clk = 1'b0;
  logic reset = 1'b1, tx_valid = 1'b0, tx_repeat = 1'b0;
  logic [7:0] tx_addr = '0, tx_cmd = '0;
  logic tx_ready, ir_out, ir_env, tx_done;
  int passed = 0, total = 0;
  logic env_a [0:MAXC-1];
  logic out_a [0:MAXC-1];
  logic rdy_a [0:MAXC-1];
  logic done_a [0:MAXC-1];
  logic env_s [0:MAXC-1];
  logic out_s [0:MAXC-1];
  nec_ir_tx #(.UNIT_CYCLES(20), .CARRIER_HALF(2)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_addr(tx_addr), .tx_cmd(tx_cmd), .tx_repeat(tx_repeat),
    .ir_out(ir_out), .ir_env(ir_env), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic sample(input int k);
    env_a[k] = ir_env;
    out_a[k] = ir_out;
    rdy_a[k] = tx_ready;
    done_a[k] = tx_done;
  endtask
  task automatic start(input logic [7:0] a, input logic [7:0] c, input logic r);
    @(negedge clk);
    tx_addr = a;
    tx_cmd = c;
    tx_repeat = r;
    tx_valid = 1'b1;
    sample(0);
  endtask
  task automatic capture(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask
  function automatic int run(input int p, input logic v);
    int n = 0;
    while (p + n < MAXC && env_a[p + n] === v) n++;
    return n;
  endfunction
  task automatic decode(input int s, output logic [31:0] w, output int bad);
    int p, l;
    bad = 0;
    w = '0;
    p = s;
    if (run(p, 1'b1) != 320) bad++;
    p += 320;
    l = run(p, 1'b0);
    if (l != 160) bad++;
    p += l;
    for (int i = 0; i < 32; i++) begin
      if (run(p, 1'b1) != 20) bad++;
      p += 20;
      l = run(p, 1'b0);
      w[i] = l == 60;
      if (l != 20 && l != 60) bad++;
      p += l;
    end
    if (run(p, 1'b1) != 20) bad++;
    p += 20;
    if (env_a[p] !== 1'b0) bad++;
  endtask
  function automatic int count_low(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (rdy_a[k] === 1'b0) n++;
    return n;
  endfunction
  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (done_a[k] === 1'b1) n++;
    return n;
  endfunction
  function automatic int carrier_errs(input int a, input int b);
    int n = 0, st = a;
    for (int k = a; k <= b; k++) begin
      if (env_a[k] === 1'b1 && env_a[k-1] === 1'b0) st = k;
      if (out_a[k] !== (env_a[k] === 1'b1 && ((k - st) % 4) < 2)) n++;
    end
    return n;
  endfunction
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx_ready); else passed++;
    total++; if (ir_out !== 1'b0) $display("FAIL reset_ir_out got %b want 0", ir_out); else passed++;
    total++; if (ir_env !== 1'b0) $display("FAIL reset_ir_env got %b want 0", ir_env); else passed++;
    total++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done got %b want 0", tx_done); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_frame_00_ff;
    logic [31:0] w;
    int bad, n;
    start(8'h00, 8'hFF, 1'b0);
    capture(1, 1);
    tx_valid = 1'b0;
    capture(2, 2430);
    n = 0;
    for (int k = 1; k <= 320; k++) if (env_a[k] !== 1'b1) n++;
    total++; if (n != 0 || env_a[0] !== 1'b0) $display("FAIL f00_lead_mark bad_cycles %0d env0 %b want 0 0", n, env_a[0]); else passed++;
    n = 0;
    for (int k = 321; k <= 480; k++) if (env_a[k] !== 1'b0) n++;
    total++; if (n != 0 || env_a[481] !== 1'b1) $display("FAIL f00_lead_space bad_cycles %0d env481 %b want 0 1", n, env_a[481]); else passed++;
    decode(1, w, bad);
    total++; if (w !== 32'h00FFFF00 || bad != 0) $display("FAIL f00_decode got %h bad %0d want 00ffff00 0", w, bad); else passed++;
    n = count_low(1, 2430);
    total++; if (n != 2420 || rdy_a[1] !== 1'b0 || rdy_a[2421] !== 1'b1) $display("FAIL f00_busy got %0d want 2420", n); else passed++;
    n = count_done(1, 2430);
    total++; if (n != 1 || done_a[2421] !== 1'b1) $display("FAIL f00_done count %0d at2421 %b want 1 1", n, done_a[2421]); else passed++;
  endtask
  task automatic test_frame_5a_c3;
    logic [31:0] w;
    int bad, n;
    start(8'h5A, 8'hC3, 1'b0);
    capture(1, 1);
    tx_valid = 1'b0;
    capture(2, 2430);
    decode(1, w, bad);
    total++; if (w !== 32'h3CC3A55A || bad != 0) $display("FAIL f5a_decode got %h bad %0d want 3cc3a55a 0", w, bad); else passed++;
    n = count_low(1, 2430);
    total++; if (n != 2420) $display("FAIL f5a_busy got %0d want 2420", n); else passed++;
    total++; if ({out_a[1], out_a[2], out_a[3], out_a[4], out_a[5]} !== 5'b11001) $display("FAIL f5a_first_carrier got %b want 11001", {out_a[1], out_a[2], out_a[3], out_a[4], out_a[5]}); else passed++;
    n = carrier_errs(1, 2430);
    total++; if (n != 0) $display("FAIL f5a_carrier bad_cycles %0d want 0", n); else passed++;
    for (int k = 0; k < MAXC; k++) begin
      env_s[k] = env_a[k];
      out_s[k] = out_a[k];
    end
  endtask
  task automatic test_repeat;
    int n, l1, l2, l3;
    start(8'hA7, 8'h19, 1'b1);
    capture(1, 1);
    tx_valid = 1'b0;
    tx_repeat = 1'b0;
    capture(2, 440);
    l1 = run(1, 1'b1);
    l2 = run(1 + l1, 1'b0);
    l3 = run(1 + l1 + l2, 1'b1);
    total++; if (l1 != 320 || l2 != 80 || l3 != 20) $display("FAIL rpt_runs got %0d/%0d/%0d want 320/80/20", l1, l2, l3); else passed++;
    n = 0;
    for (int k = 421; k <= 440; k++) if (env_a[k] !== 1'b0) n++;
    total++; if (n != 0) $display("FAIL rpt_tail_env bad_cycles %0d want 0", n); else passed++;
    n = count_low(1, 440);
    total++; if (n != 420) $display("FAIL rpt_busy got %0d want 420", n); else passed++;
    n = count_done(1, 440);
    total++; if (n != 1 || done_a[421] !== 1'b1) $display("FAIL rpt_done count %0d at421 %b want 1 1", n, done_a[421]); else passed++;
  endtask
  task automatic test_back_to_back;
    logic [31:0] w;
    int bad, n;
    start(8'h12, 8'h34, 1'b0);
    capture(1, 100);
    tx_addr = 8'hAB;
    tx_cmd = 8'hCD;
    capture(101, 2422);
    tx_valid = 1'b0;
    capture(2423, 4850);
    decode(1, w, bad);
    total++; if (w !== 32'hCB34ED12 || bad != 0) $display("FAIL b2b_first got %h bad %0d want cb34ed12 0", w, bad); else passed++;
    total++; if ({env_a[2420], env_a[2421], env_a[2422]} !== 3'b101) $display("FAIL b2b_gap got %b want 101", {env_a[2420], env_a[2421], env_a[2422]}); else passed++;
    total++; if (rdy_a[2421] !== 1'b1 || done_a[2421] !== 1'b1 || rdy_a[2422] !== 1'b0) $display("FAIL b2b_handoff rdy %b done %b rdy_next %b want 1 1 0", rdy_a[2421], done_a[2421], rdy_a[2422]); else passed++;
    decode(2422, w, bad);
    total++; if (w !== 32'h32CD54AB || bad != 0) $display("FAIL b2b_second got %h bad %0d want 32cd54ab 0", w, bad); else passed++;
    n = count_done(1, 4850);
    total++; if (n != 2 || done_a[4842] !== 1'b1) $display("FAIL b2b_done count %0d at4842 %b want 2 1", n, done_a[4842]); else passed++;
  endtask
  task automatic test_reset_mid_frame;
    int n;
    start(8'h00, 8'h00, 1'b0);
    capture(1, 1);
    tx_valid = 1'b0;
    capture(2, 990);
    total++; if (env_a[980] !== 1'b1 || env_a[981] !== 1'b0 || env_a[990] !== 1'b0) $display("FAIL rmid_position env980 %b env981 %b want 1 0", env_a[980], env_a[981]); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if ({ir_out, ir_env, tx_ready, tx_done} !== 4'b0010) $display("FAIL rmid_outputs got %b want 0010", {ir_out, ir_env, tx_ready, tx_done}); else passed++;
    reset = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if ({ir_env, tx_ready, tx_done} !== 3'b010) n++;
    end
    total++; if (n != 0) $display("FAIL rmid_stays_idle bad_cycles %0d want 0", n); else passed++;
    start(8'h5A, 8'hC3, 1'b0);
    capture(1, 1);
    tx_valid = 1'b0;
    capture(2, 2430);
    n = 0;
    for (int k = 0; k <= 2430; k++) if (env_a[k] !== env_s[k] || out_a[k] !== out_s[k]) n++;
    total++; if (n != 0) $display("FAIL rmid_restart diff_cycles %0d want 0", n); else passed++;
  endtask
  task automatic test_valid_in_reset;
    int n;
    @(negedge clk);
    reset = 1'b1;
    tx_valid = 1'b1;
    tx_repeat = 1'b0;
    @(negedge clk);
    total++; if ({ir_out, ir_env, tx_ready} !== 3'b001) $display("FAIL vres_during got %b want 001", {ir_out, ir_env, tx_ready}); else passed++;
    reset = 1'b0;
    tx_valid = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if ({ir_out, ir_env, tx_ready, tx_done} !== 4'b0010) n++;
    end
    total++; if (n != 0) $display("FAIL vres_after bad_cycles %0d want 0", n); else passed++;
  endtask
  initial begin
    test_reset;
    test_frame_00_ff;
    test_frame_5a_c3;
    test_repeat;
    test_back_to_back;
    test_reset_mid_frame;
    test_valid_in_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
